// File: rtl/alu_share_arb.sv
// Round-robin arbiter/sequencer sharing one external combinational ALU among NREQ requesters.
// Define ALU_ARB_FIXED_PRIO_EN for fixed lowest-index-wins priority instead of round-robin.
module alu_share_arb #(
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [32*NREQ-1:0]   req_op1,
  input  logic [32*NREQ-1:0]   req_op2,
  input  logic [3*NREQ-1:0]    req_ctrl,
  output logic [31:0]          alu_op1,
  output logic [31:0]          alu_op2,
  output logic [2:0]           alu_control,
  input  logic [31:0]          alu_result,
  input  logic                 alu_zero,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [31:0]          rsp_data,
  output logic                 rsp_zero,
  output logic [1:0]           rsp_id,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t      state_q;
  logic [1:0]  win_q, win_d, start;
  logic        found;
  logic [31:0] alu_op1_q, alu_op2_q, rsp_data_q;
  logic [2:0]  alu_ctrl_q;
  logic        rsp_valid_q, rsp_zero_q;
  logic [1:0]  rsp_id_q;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign start = 2'd0;
`else
  logic [1:0] rr_q;
  assign start = rr_q;
`endif

  // First valid requester at or after start, wrapping modulo NREQ.
  always_comb begin
    int idx;
    found = 1'b0;
    win_d = 2'd0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(start) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win_d = 2'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++)
      req_ready[i] = (state_q == IDLE) && found && (win_d == 2'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      win_q       <= 2'd0;
      alu_op1_q   <= '0;
      alu_op2_q   <= '0;
      alu_ctrl_q  <= 3'b000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_id_q    <= 2'd0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      rr_q        <= 2'd0;
`endif
    end else begin
      case (state_q)
        IDLE: if (found) begin
          alu_op1_q  <= req_op1[win_d*32 +: 32];
          alu_op2_q  <= req_op2[win_d*32 +: 32];
          alu_ctrl_q <= req_ctrl[win_d*3 +: 3];
          win_q      <= win_d;
          state_q    <= EXEC;
        end
        EXEC: begin
          rsp_data_q  <= alu_result;
          rsp_zero_q  <= alu_zero;
          rsp_id_q    <= win_q;
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
`ifndef ALU_ARB_FIXED_PRIO_EN
          rr_q        <= (win_q == 2'(NREQ-1)) ? 2'd0 : win_q + 2'd1;
`endif
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign alu_op1     = alu_op1_q;
  assign alu_op2     = alu_op2_q;
  assign alu_control = alu_ctrl_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_zero    = rsp_zero_q;
  assign rsp_id      = rsp_id_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: vector table over all ALU codes plus contention,
// backpressure and mid-operation reset sequences, with a reference ALU model.
module tb_alu_share_arb;
  localparam int NREQ = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [NREQ-1:0]   req_ready;
  logic [32*NREQ-1:0] req_op1 = '0, req_op2 = '0;
  logic [3*NREQ-1:0] req_ctrl = '0;
  logic [31:0]       alu_op1, alu_op2, alu_result;
  logic [2:0]        alu_control;
  logic              alu_zero;
  logic              rsp_valid, rsp_ready = 1'b1, rsp_zero, busy;
  logic [31:0]       rsp_data;
  logic [1:0]        rsp_id;

  int errors = 0;
  int checks = 0;

  alu_share_arb #(.NREQ(NREQ)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op1(req_op1), .req_op2(req_op2), .req_ctrl(req_ctrl),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  // External shared ALU
  always_comb begin
    case (alu_control)
      3'b000:  alu_result = alu_op1 + alu_op2;
      3'b001:  alu_result = alu_op1 - alu_op2;
      3'b010:  alu_result = alu_op1 << alu_op2[4:0];
      3'b011:  alu_result = alu_op1 >> alu_op2[4:0];
      3'b100:  alu_result = alu_op1 & alu_op2;
      3'b101:  alu_result = alu_op1 | alu_op2;
      3'b110:  alu_result = alu_op1 ^ alu_op2;
      default: alu_result = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
    endcase
    alu_zero = (alu_result == 32'd0);
  end

  typedef struct {
    logic [31:0] op1;
    logic [31:0] op2;
    logic [2:0]  ctrl;
    logic [31:0] exp_data;
    logic        exp_zero;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
    req_op1[r*32 +: 32] = a;
    req_op2[r*32 +: 32] = b;
    req_ctrl[r*3 +: 3]  = c;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    logic [1:0]  exp_win;
    logic [31:0] held;

    vecs[0] = '{32'd5,        32'd3,        3'b001, 32'd2,        1'b0};
    vecs[1] = '{32'hA5A5A5A5, 32'hA5A5A5A5, 3'b110, 32'd0,        1'b1};
    vecs[2] = '{32'd1,        32'd2,        3'b111, 32'd1,        1'b0};
    vecs[3] = '{32'hFFFFFFFF, 32'd1,        3'b000, 32'd0,        1'b1};
    vecs[4] = '{32'd1,        32'd31,       3'b010, 32'h80000000, 1'b0};
    vecs[5] = '{32'h80000000, 32'd4,        3'b011, 32'h08000000, 1'b0};
    vecs[6] = '{32'hF0F0F0F0, 32'h0FF00FF0, 3'b100, 32'h00F000F0, 1'b0};
    vecs[7] = '{32'hF0F0F0F0, 32'h0F0F0F0F, 3'b101, 32'hFFFFFFFF, 1'b0};
    vecs[8] = '{32'hFFFFFFFF, 32'd1,        3'b111, 32'd1,        1'b0};
    vecs[9] = '{32'd7,        32'd7,        3'b001, 32'd0,        1'b1};

    // Reset state
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_alu_op1", alu_op1, 32'd0);
    chk("rst_alu_op2", alu_op2, 32'd0);
    chk("rst_alu_ctrl", 32'(alu_control), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_zero", 32'(rsp_zero), 32'd0);
    chk("rst_rsp_id", 32'(rsp_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    do_reset();
    chk("idle_no_req_ready", 32'(req_ready), 32'd0);

    // Vector table, alternating single requesters
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int r;
      r = i % 2;
      set_req(r, vecs[i].op1, vecs[i].op2, vecs[i].ctrl);
      req_valid = '0;
      req_valid[r] = 1'b1;
      #1;
      chk($sformatf("v%0d_grant", i), 32'(req_ready), 32'(1 << r));
      step();
      req_valid = '0;
      chk($sformatf("v%0d_exec_busy", i), 32'(busy), 32'd1);
      chk($sformatf("v%0d_exec_rv", i), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d_alu_op1", i), alu_op1, vecs[i].op1);
      chk($sformatf("v%0d_alu_ctrl", i), 32'(alu_control), 32'(vecs[i].ctrl));
      chk($sformatf("v%0d_exec_ready", i), 32'(req_ready), 32'd0);
      step();
      chk($sformatf("v%0d_rsp_valid", i), 32'(rsp_valid), 32'd1);
      chk($sformatf("v%0d_rsp_data", i), rsp_data, vecs[i].exp_data);
      chk($sformatf("v%0d_rsp_zero", i), 32'(rsp_zero), 32'(vecs[i].exp_zero));
      chk($sformatf("v%0d_rsp_id", i), 32'(rsp_id), 32'(r));
      step();
      chk($sformatf("v%0d_idle_rv", i), 32'(rsp_valid), 32'd0);
      chk($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_alu_hold", i), alu_op1, vecs[i].op1);
    end

    // Contention: both requesters held for 4 ops
    do_reset();
    set_req(0, 32'd10, 32'd3, 3'b000);
    set_req(1, 32'd20, 32'd5, 3'b001);
    req_valid = 2'b11;
    for (int k = 0; k < 4; k++) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      exp_win = 2'd0;
`else
      exp_win = 2'(k % 2);
`endif
      #1;
      chk($sformatf("cont%0d_grant", k), 32'(req_ready), 32'(1 << exp_win));
      step();
      step();
      chk($sformatf("cont%0d_rsp_id", k), 32'(rsp_id), 32'(exp_win));
      chk($sformatf("cont%0d_rsp_data", k), rsp_data, (exp_win == 2'd0) ? 32'd13 : 32'd15);
      step();
    end
    req_valid = '0;

    // Backpressure held in RESP while requester 1 waits
    set_req(0, 32'd9, 32'd4, 3'b001);
    set_req(1, 32'd3, 32'd3, 3'b110);
    req_valid = 2'b01;
    rsp_ready = 1'b0;
    #1;
    chk("bp_grant0", 32'(req_ready), 32'd1);
    step();
    req_valid = 2'b10;
    step();
    held = rsp_data;
    chk("bp_rsp_data", held, 32'd5);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_valid", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("bp%0d_data", c), rsp_data, 32'd5);
      chk($sformatf("bp%0d_id", c), 32'(rsp_id), 32'd0);
      chk($sformatf("bp%0d_ready", c), 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    step();
    chk("bp_grant1", 32'(req_ready), 32'd2);
    step();
    req_valid = '0;
    step();
    chk("bp_rsp_id1", 32'(rsp_id), 32'd1);
    chk("bp_rsp_zero1", 32'(rsp_zero), 32'd1);
    step();

    // Reset during EXEC
    set_req(0, 32'd8, 32'd1, 3'b000);
    req_valid = 2'b01;
    step();
    req_valid = '0;
    chk("mr_in_exec", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_alu_op1", alu_op1, 32'd0);
    chk("mr_alu_op2", alu_op2, 32'd0);
    chk("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("mr_rsp_data", rsp_data, 32'd0);
    chk("mr_rsp_id", 32'(rsp_id), 32'd0);
    #3;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      step();
      chk($sformatf("mr_post%0d_rv", c), 32'(rsp_valid), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
